// File: rtl/poly_mul_modq.sv
// Streaming polynomial multiplier: z = p*u mod (x^N +/- 1), coefficients reduced mod Q.
// Joint p/u beat handshake, N-cycle compute phase, then back-pressured result stream.
module poly_mul_modq #(
    parameter int unsigned N  = 8,
    parameter int unsigned QW = 8,
    parameter int unsigned UW = 2,
    parameter int unsigned Q  = 251
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic [QW-1:0] p_data,
    input  logic          p_vld,
    input  logic          p_last,
    output logic          p_rdy,
    input  logic [UW-1:0] u_data,
    input  logic          u_vld,
    input  logic          u_last,
    output logic          u_rdy,
    input  logic          mode_neg,
    output logic [QW-1:0] z_data,
    output logic          z_vld,
    output logic          z_last,
    input  logic          z_rdy,
    output logic          err
);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = QW + UW;
    localparam logic [CW-1:0] LastIdx = CW'(N - 1);
    localparam logic [CW-1:0] One     = CW'(1);
    localparam logic [QW-1:0] QData   = QW'(Q);
    localparam logic [QW:0]   QExt    = (QW + 1)'(Q);
    localparam logic [PW-1:0] QProd   = PW'(Q);

    typedef enum logic [1:0] {StLoad = 2'd0, StCalc = 2'd1, StOut = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [QW-1:0] p_q [N];
    logic [QW-1:0] p_d [N];
    logic [UW-1:0] u_q [N];
    logic [UW-1:0] u_d [N];
    logic [QW-1:0] acc_q [N];
    logic [QW-1:0] acc_d [N];
    logic          mode_q, mode_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;
    logic [QW-1:0] z_data_q, z_data_d;
    logic          z_vld_q, z_vld_d;
    logic          z_last_q, z_last_d;

    logic [PW-1:0] prod [N];
    logic [QW-1:0] pm [N];
    logic [QW:0]   sum [N];
    logic [QW-1:0] add_res [N];
    logic [QW-1:0] sub_res [N];
    logic          neg [N];
    logic          beat, bad;

    assign cnt_inc = cnt_q + One;
    assign beat    = (state_q == StLoad) && rdy_q && p_vld && u_vld;
    assign bad     = (p_last != u_last) || (p_data >= QData) ||
                     ((cnt_q != LastIdx) && (p_last || u_last)) ||
                     ((cnt_q == LastIdx) && !(p_last && u_last));

    // Accumulator k receives p[i]*u[(k-i) mod N]; the term wrapped past x^N iff i > k.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod[k]    = PW'(p_q[cnt_q]) * PW'(u_q[CW'(k) - cnt_q]);
            pm[k]      = QW'(prod[k] % QProd);
            sum[k]     = {1'b0, acc_q[k]} + {1'b0, pm[k]};
            add_res[k] = (sum[k] >= QExt) ? QW'(sum[k] - QExt) : QW'(sum[k]);
            sub_res[k] = (acc_q[k] >= pm[k]) ? (acc_q[k] - pm[k])
                                             : QW'({1'b0, acc_q[k]} + QExt - {1'b0, pm[k]});
            neg[k]     = mode_q && (cnt_q > CW'(k));
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        u_d      = u_q;
        acc_d    = acc_q;
        mode_d   = mode_q;
        rdy_d    = rdy_q;
        err_d    = 1'b0;
        z_data_d = z_data_q;
        z_vld_d  = z_vld_q;
        z_last_d = z_last_q;
        case (state_q)
            StLoad: begin
                rdy_d = 1'b1;
                if (beat) begin
                    if (bad) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        p_d[cnt_q] = p_data;
                        u_d[cnt_q] = u_data;
                        if (cnt_q == '0) mode_d = mode_neg;
                        if (cnt_q == LastIdx) begin
                            state_d = StCalc;
                            cnt_d   = '0;
                            rdy_d   = 1'b0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
            end
            StCalc: begin
                for (int k = 0; k < N; k++) acc_d[k] = neg[k] ? sub_res[k] : add_res[k];
                if (cnt_q == LastIdx) begin
                    state_d = StOut;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StOut: begin
                if (!z_vld_q) begin
                    z_vld_d  = 1'b1;
                    z_data_d = acc_q[cnt_q];
                    z_last_d = (cnt_q == LastIdx);
                end else if (z_rdy) begin
                    if (z_last_q) begin
                        z_vld_d  = 1'b0;
                        z_last_d = 1'b0;
                        z_data_d = '0;
                        acc_d    = '{default: '0};
                        cnt_d    = '0;
                        rdy_d    = 1'b1;
                        state_d  = StLoad;
                    end else begin
                        cnt_d    = cnt_inc;
                        z_data_d = acc_q[cnt_inc];
                        z_last_d = (cnt_inc == LastIdx);
                    end
                end
            end
            default: begin
                state_d  = StLoad;
                cnt_d    = '0;
                acc_d    = '{default: '0};
                rdy_d    = 1'b0;
                z_data_d = '0;
                z_vld_d  = 1'b0;
                z_last_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q  <= StLoad;
            cnt_q    <= '0;
            p_q      <= '{default: '0};
            u_q      <= '{default: '0};
            acc_q    <= '{default: '0};
            mode_q   <= 1'b0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            z_data_q <= '0;
            z_vld_q  <= 1'b0;
            z_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            u_q      <= u_d;
            acc_q    <= acc_d;
            mode_q   <= mode_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            z_data_q <= z_data_d;
            z_vld_q  <= z_vld_d;
            z_last_q <= z_last_d;
        end
    end

    assign p_rdy  = rdy_q;
    assign u_rdy  = rdy_q;
    assign err    = err_q;
    assign z_data = z_data_q;
    assign z_vld  = z_vld_q;
    assign z_last = z_last_q;
endmodule

// File: doc/poly_mul_modq.md
Name: poly_mul_modq

Overview:
- Parametrised successor to the streaming polynomial multiplier used in the FV encoder datapath.
- Computes z = p·u mod (x^N ± 1) with every coefficient reduced mod Q.
- Mode is selectable per polynomial: negacyclic (x^N+1) or cyclic (x^N−1).
- Adds output back-pressure, length/range error reporting and a defined compute phase; sits between coefficient sources and the encoder output stage.

Parameters:
- N, 8: polynomial length; power of 2, ≥2.
- QW, 8: coefficient width of p and z.
- UW, 2: coefficient width of u (unsigned).
- Q, 251: modulus; 2 ≤ Q < 2^QW.

Ports:
- clk  in  1  system clock
- s_rst_n  in  1  reset; one clock, synchronous, active-low
- p_data  in  QW  p coefficient, index 0 first
- p_vld  in  1  p beat valid
- p_last  in  1  p final beat
- p_rdy  out  1  p ready
- u_data  in  UW  u coefficient
- u_vld  in  1  u beat valid
- u_last  in  1  u final beat
- u_rdy  out  1  u ready (always equal to p_rdy)
- mode_neg  in  1  1: mod x^N+1, 0: mod x^N−1; sampled on beat 0
- z_data  out  QW  result coefficient, index 0 first
- z_vld  out  1  z valid
- z_last  out  1  z final coefficient (index N−1)
- z_rdy  in  1  downstream ready
- err  out  1  one-cycle error pulse

Behaviour:
- Reset (s_rst_n=0 at posedge):
  - p_rdy, u_rdy, z_vld, z_last, err, z_data = 0.
  - Coefficient stores, accumulators and counters cleared; state=LOAD.
  - p_rdy/u_rdy rise in the first cycle after reset deasserts.
  - Reset in any state aborts the polynomial in flight; no partial output is emitted.
- States: LOAD → CALC → OUT → LOAD.
- LOAD:
  - p_rdy = u_rdy = 1.
  - A beat is accepted only when p_vld & u_vld & rdy (joint handshake). A lone p_vld or u_vld is not consumed.
  - Beat k is stored at index k; mode_neg is latched on beat 0.
- Length/range checks (any failure: err=1 for one cycle after the offending beat, polynomial discarded, beat count reset to 0, stay in LOAD):
  - last (p_last | u_last) on beat k < N−1.
  - Beat N−1 without both p_last and u_last.
  - p_last ≠ u_last on the same beat.
  - p_data ≥ Q.
- Beat N−1 accepted with both last flags: rdy drops the next cycle and state → CALC.
- CALC (exactly N cycles, i = 0..N−1):
  - Cycle i adds p[i]·u[j] into acc[(i+j) mod N] for all j in parallel (N multipliers).
  - If i+j ≥ N and the latched mode is negacyclic, the term is subtracted.
  - acc is held in [0,Q). Add: s = a + (prod mod Q), subtract Q if s ≥ Q. Subtract: d = a − (prod mod Q), add Q if d < 0.
  - Internal width ≥ QW+1 so nothing overflows; prod width QW+UW.
- OUT:
  - z_vld=1 from the cycle after CALC ends (first z_vld at N+1 cycles after the last input handshake).
  - Streams acc[0..N−1]; a transfer occurs on z_vld & z_rdy.
  - While z_rdy=0, z_data/z_vld/z_last hold stable.
  - z_last=1 only with acc[N−1].
  - After the final transfer: z_vld=0 and p_rdy=u_rdy=1 in the next cycle, accumulators cleared, state → LOAD.
- No input is accepted during CALC or OUT (rdy=0).
- An unreachable state encoding recovers to LOAD with outputs at their reset values.

Test Plan:
1. N=4, Q=17, UW=2, mode_neg=1, p=[1,2,3,4], u=[1,1,0,0], z_rdy=1 → z=[14,3,5,7]; z_last on the 4th beat; first z_vld exactly 5 cycles after the last input handshake.
2. Same stimulus, mode_neg=0 → z=[5,3,5,7]; then immediate back-to-back polynomial with mode_neg=1 → [14,3,5,7] (mode latched per polynomial).
3. N=4, Q=17, p=[16,16,16,16], u=[3,3,3,3], negacyclic → z=[6,0,11,5] (wrap and modular subtract).
4. Case 1 with z_rdy toggled 1,0,0,1,… → same 4 values in order, each held stable while z_rdy=0; p_rdy stays 0 until the final transfer.
5. N=4: last on beat 2 → err one-cycle pulse, no z_vld; next valid polynomial (case 1) → [14,3,5,7]. Also p_data=17 (≥Q) → err, polynomial discarded.
6. s_rst_n=0 asserted during OUT after 2 transfers → all outputs 0 the next cycle, rdy=1 one cycle after release; case 1 then yields [14,3,5,7].
